// File: rtl/axis_bram_writer.sv
// AXI4-Stream slave capturing one frame into BRAM port A.
// Define AXIS_BRAM_WRITER_WRAP_EN for ring-buffer mode with sts_wrap.
module axis_bram_writer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 14
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_data,
  input  logic                         cfg_arm,
  output logic [BRAM_ADDR_WIDTH:0]     sts_data,
  output logic                         sts_busy,
  output logic                         sts_done,
`ifdef AXIS_BRAM_WRITER_WRAP_EN
  output logic                         sts_wrap,
`endif
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);

  localparam int AW   = BRAM_ADDR_WIDTH;
  localparam int WE_W = BRAM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cntr_q, cntr_d;
  logic [AW-1:0] last_q, last_d;
  logic          accept;
  logic          at_last;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
  logic          wrap_q, wrap_d;
`endif

  assign accept  = s_axis_tvalid & s_axis_tready;
  assign at_last = (cntr_q[AW-1:0] == last_q);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      last_q  <= '0;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      last_q  <= last_d;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    last_d  = last_q;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
    wrap_d  = wrap_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (cfg_arm) begin
          state_d = WRITE;
          cntr_d  = '0;
          last_d  = cfg_data;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
          wrap_d  = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (accept) begin
`ifdef AXIS_BRAM_WRITER_WRAP_EN
          // Ring mode: address limit wraps, only tlast ends
          if (at_last) begin
            cntr_d = '0;
            wrap_d = 1'b1;
          end else begin
            cntr_d = cntr_q + {{AW{1'b0}}, 1'b1};
          end
          if (s_axis_tlast)
            state_d = DONE;
`else
          cntr_d = cntr_q + {{AW{1'b0}}, 1'b1};
          if (at_last || s_axis_tlast)
            state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_axis_tready     = (state_q == WRITE);
  assign sts_busy          = (state_q == WRITE);
  assign sts_done          = (state_q == DONE);
  assign sts_data          = cntr_q;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
  assign sts_wrap          = wrap_q;
`endif

  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = areset;
  assign bram_porta_addr   = cntr_q[AW-1:0];
  assign bram_porta_wrdata = s_axis_tdata;
  assign bram_porta_we     = {WE_W{accept}};

endmodule

// File: tb/tb_axis_bram_writer.sv
// Randomized self-checking bench for axis_bram_writer.
// Build with AXIS_BRAM_WRITER_WRAP_EN to exercise ring mode.
module tb_axis_bram_writer;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam logic [3:0] WE_ALL = 4'hF;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] cfg_data;
  logic          cfg_arm;
  logic [AW:0]   sts_data;
  logic          sts_busy;
  logic          sts_done;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
  logic          sts_wrap;
`endif
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          bram_porta_clk;
  logic          bram_porta_rst;
  logic [AW-1:0] bram_porta_addr;
  logic [DW-1:0] bram_porta_wrdata;
  logic [3:0]    bram_porta_we;

  always #5 aclk = ~aclk;

  axis_bram_writer #(
    .AXIS_TDATA_WIDTH(DW),
    .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_data(cfg_data),
    .cfg_arm(cfg_arm),
    .sts_data(sts_data),
    .sts_busy(sts_busy),
    .sts_done(sts_done),
`ifdef AXIS_BRAM_WRITER_WRAP_EN
    .sts_wrap(sts_wrap),
`endif
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .bram_porta_clk(bram_porta_clk),
    .bram_porta_rst(bram_porta_rst),
    .bram_porta_addr(bram_porta_addr),
    .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we(bram_porta_we)
  );

  int checks = 0;
  int failures = 0;
  int obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [DW-1:0] exp_data[$];
  int we_bad;

  // Reference model: words, address of k-th write, final status
  function automatic int exp_words(int cfg, int tl);
`ifdef AXIS_BRAM_WRITER_WRAP_EN
    return tl + 1;
`else
    if (tl < 0 || tl > cfg) return cfg + 1;
    return tl + 1;
`endif
  endfunction

  function automatic int exp_addr(int k, int cfg);
`ifdef AXIS_BRAM_WRITER_WRAP_EN
    return k % (cfg + 1);
`else
    return k;
`endif
  endfunction

  function automatic int exp_sts(int n, int cfg);
`ifdef AXIS_BRAM_WRITER_WRAP_EN
    return n % (cfg + 1);
`else
    return n;
`endif
  endfunction

  // vpat: 0 full rate, 1 toggling, 2 random valid
  task automatic drive_capture(input int cfg, input int tl,
                               input int vpat, input int arm_at,
                               input int rst_at);
    int sent;
    int budget;
    logic v;
    logic acc;
    sent = 0;
    obs_addr.delete();
    obs_data.delete();
    exp_data.delete();
    we_bad = 0;
    budget = 3 * ((tl > cfg ? tl : cfg) + 1) + 40;
    @(posedge aclk); #1;
    cfg_data = AW'(cfg);
    cfg_arm  = 1'b1;
    @(posedge aclk); #1;
    cfg_arm  = 1'b0;
    cfg_data = AW'($urandom);
    for (int cyc = 0; cyc < budget; cyc++) begin
      case (vpat)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      areset = (sent == rst_at);
      if (areset) v = 1'b0;
      s_axis_tvalid = v;
      s_axis_tdata  = $urandom;
      s_axis_tlast  = (sent == tl);
      cfg_arm       = (sent == arm_at);
      if (cfg_arm) cfg_data = AW'($urandom);
      @(negedge aclk);
      acc = v && s_axis_tready;
      if (acc) begin
        exp_data.push_back(s_axis_tdata);
        sent++;
      end
      if (bram_porta_we !== (acc ? WE_ALL : 4'h0)) we_bad++;
      if (bram_porta_we != 4'h0) begin
        obs_addr.push_back(int'(bram_porta_addr));
        obs_data.push_back(bram_porta_wrdata);
      end
      @(posedge aclk); #1;
      cfg_arm = 1'b0;
      if (areset) begin
        areset = 1'b0;
        break;
      end
      if (sts_done) break;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_arm       = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    cfg_arm = 1'b0;
    cfg_data = '0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hDEAD_BEEF;
    s_axis_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b0 || bram_porta_we !== 4'h0) begin
      failures++;
      $display("FAIL reset_io tready=%b we=%h exp 0/0",
               s_axis_tready, bram_porta_we);
    end
    checks++;
    if (sts_data !== '0 || sts_busy !== 1'b0 || sts_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_sts data=%0d busy=%b done=%b exp 0/0/0",
               sts_data, sts_busy, sts_done);
    end
    checks++;
    if (bram_porta_rst !== 1'b0) begin
      failures++;
      $display("FAIL reset_bram_rst got=%b exp=0", bram_porta_rst);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_full_rate();
    drive_capture(7, -1, 0, -1, -1);
    checks++;
    if (obs_addr.size() != 8 || we_bad != 0) begin
      failures++;
      $display("FAIL full_writes got=%0d bad_we=%0d exp 8/0",
               obs_addr.size(), we_bad);
    end
    for (int k = 0; k < obs_addr.size() && k < exp_data.size(); k++) begin
      checks++;
      if (obs_addr[k] != k || obs_data[k] !== exp_data[k]) begin
        failures++;
        $display("FAIL full_beat%0d addr=%0d data=%h exp %0d/%h",
                 k, obs_addr[k], obs_data[k], k, exp_data[k]);
      end
    end
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b0 || sts_data !== 15'd8 ||
        sts_done !== 1'b1 || sts_busy !== 1'b0) begin
      failures++;
      $display("FAIL full_done rdy=%b data=%0d done=%b busy=%b exp 0/8/1/0",
               s_axis_tready, sts_data, sts_done, sts_busy);
    end
  endtask

  task automatic test_tlast();
    drive_capture(15, 4, 0, -1, -1);
    checks++;
    if (obs_addr.size() != 5 || we_bad != 0) begin
      failures++;
      $display("FAIL tlast_writes got=%0d bad_we=%0d exp 5/0",
               obs_addr.size(), we_bad);
    end
    for (int k = 0; k < obs_addr.size(); k++) begin
      checks++;
      if (obs_addr[k] != k) begin
        failures++;
        $display("FAIL tlast_addr%0d got=%0d exp=%0d", k, obs_addr[k], k);
      end
    end
    checks++;
    if (sts_data !== 15'd5 || sts_done !== 1'b1) begin
      failures++;
      $display("FAIL tlast_sts data=%0d done=%b exp 5/1",
               sts_data, sts_done);
    end
  endtask

  task automatic test_toggle();
    drive_capture(3, -1, 1, -1, -1);
    checks++;
    if (obs_addr.size() != 4 || we_bad != 0) begin
      failures++;
      $display("FAIL toggle_writes got=%0d bad_we=%0d exp 4/0",
               obs_addr.size(), we_bad);
    end
    for (int k = 0; k < obs_addr.size() && k < exp_data.size(); k++) begin
      checks++;
      if (obs_addr[k] != k || obs_data[k] !== exp_data[k]) begin
        failures++;
        $display("FAIL toggle_beat%0d addr=%0d exp=%0d", k, obs_addr[k], k);
      end
    end
  endtask

  task automatic test_arm_ignored();
    drive_capture(3, -1, 0, 2, -1);
    checks++;
    if (obs_addr.size() != 4 || sts_data !== 15'd4 || sts_done !== 1'b1) begin
      failures++;
      $display("FAIL armwr_writes got=%0d sts=%0d done=%b exp 4/4/1",
               obs_addr.size(), sts_data, sts_done);
    end
    for (int k = 0; k < obs_addr.size(); k++) begin
      checks++;
      if (obs_addr[k] != k) begin
        failures++;
        $display("FAIL armwr_addr%0d got=%0d exp=%0d", k, obs_addr[k], k);
      end
    end
    @(posedge aclk); #1;
    cfg_data = AW'(5);
    cfg_arm  = 1'b1;
    @(posedge aclk); #1;
    cfg_arm  = 1'b0;
    checks++;
    if (sts_done !== 1'b0 || sts_busy !== 1'b1 || sts_data !== '0) begin
      failures++;
      $display("FAIL rearm_sts done=%b busy=%b data=%0d exp 0/1/0",
               sts_done, sts_busy, sts_data);
    end
    drive_capture(5, -1, 0, -1, -1);
    checks++;
    if (obs_addr.size() != 6 || sts_data !== 15'd6) begin
      failures++;
      $display("FAIL rearm_writes got=%0d sts=%0d exp 6/6",
               obs_addr.size(), sts_data);
    end
    checks++;
    if (obs_addr.size() == 0 || obs_addr[0] != 0) begin
      failures++;
      $display("FAIL rearm_first got=%0d exp=0",
               obs_addr.size() == 0 ? -1 : obs_addr[0]);
    end
  endtask

  task automatic test_mid_reset();
    drive_capture(9, -1, 0, -1, 3);
    checks++;
    if (obs_addr.size() != 3) begin
      failures++;
      $display("FAIL midrst_writes got=%0d exp=3", obs_addr.size());
    end
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b0 || sts_data !== '0 ||
        sts_busy !== 1'b0 || sts_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_sts rdy=%b data=%0d busy=%b done=%b exp 0",
               s_axis_tready, sts_data, sts_busy, sts_done);
    end
  endtask

  task automatic test_random();
    int cfg, tl, n, bad;
    for (int it = 0; it < 8; it++) begin
      cfg = (it == 0) ? 0 : $urandom_range(1, 20);
      tl  = (it == 1) ? cfg : $urandom_range(0, 26) - 1;
`ifdef AXIS_BRAM_WRITER_WRAP_EN
      if (tl < 0) tl = cfg + 3;
`endif
      drive_capture(cfg, tl, 2, -1, -1);
      n = exp_words(cfg, tl);
      bad = 0;
      for (int k = 0; k < obs_addr.size() && k < exp_data.size(); k++)
        if (obs_addr[k] != exp_addr(k, cfg) || obs_data[k] !== exp_data[k])
          bad++;
      checks++;
      if (obs_addr.size() != n || bad != 0 || we_bad != 0) begin
        failures++;
        $display("FAIL rand%0d cfg=%0d tl=%0d writes=%0d exp=%0d bad=%0d/%0d",
                 it, cfg, tl, obs_addr.size(), n, bad, we_bad);
      end
      checks++;
      if (sts_data !== (AW+1)'(exp_sts(n, cfg)) || sts_done !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_sts data=%0d done=%b exp %0d/1",
                 it, sts_data, sts_done, exp_sts(n, cfg));
      end
    end
  endtask

  task automatic test_full_buffer();
    int bad;
    drive_capture((1 << AW) - 1, -1, 0, -1, -1);
    bad = 0;
    for (int k = 0; k < obs_addr.size(); k++)
      if (obs_addr[k] != k) bad++;
    checks++;
    if (obs_addr.size() != (1 << AW) || bad != 0) begin
      failures++;
      $display("FAIL fullbuf_writes got=%0d bad=%0d exp=%0d/0",
               obs_addr.size(), bad, 1 << AW);
    end
    checks++;
    if (sts_data !== (AW+1)'(1 << AW) || sts_done !== 1'b1) begin
      failures++;
      $display("FAIL fullbuf_sts data=%0d done=%b exp %0d/1",
               sts_data, sts_done, 1 << AW);
    end
  endtask

`ifdef AXIS_BRAM_WRITER_WRAP_EN
  task automatic test_wrap();
    drive_capture(3, 9, 0, -1, -1);
    checks++;
    if (obs_addr.size() != 10) begin
      failures++;
      $display("FAIL wrap_writes got=%0d exp=10", obs_addr.size());
    end
    for (int k = 0; k < obs_addr.size(); k++) begin
      checks++;
      if (obs_addr[k] != k % 4) begin
        failures++;
        $display("FAIL wrap_addr%0d got=%0d exp=%0d",
                 k, obs_addr[k], k % 4);
      end
    end
    checks++;
    if (sts_wrap !== 1'b1 || sts_data !== 15'd2 || sts_done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_sts wrap=%b data=%0d done=%b exp 1/2/1",
               sts_wrap, sts_data, sts_done);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AXIS_BRAM_WRITER_WRAP_EN
    test_wrap();
    test_random();
`else
    test_full_rate();
    test_tlast();
    test_toggle();
    test_arm_ignored();
    test_mid_reset();
    test_random();
    test_full_buffer();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
